// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file: FSM state encoding,
// rw-bit meaning and the frame length derivation.
// No ports; imported by spi_regfile.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // One rw bit, then the address, then the data, MSB first.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with edge pulses.
// Ports: clk/rst_n; din (async pin); level (synced value);
//        rise/fall (one-clk pulses on synced level transitions).
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  // Edge pulses are held off until both the chain and the delayed copy
  // carry real pin samples, so a pin that already sits away from its
  // reset value at reset release is not mistaken for an edge.
  logic [STAGES:0]   warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      warm  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      warm  <= {warm[STAGES-1:0], 1'b1};
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = warm[STAGES] &  level & ~prev;
  assign fall  = warm[STAGES] & ~level &  prev;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 write (and optional read) port onto a bank of control registers.
// Ports: clk/rst_n; cs_n, sclk, copi (async SPI pins); cipo (read data);
//        regs_o (flattened bank), wr_strobe/wr_addr (commit), frame_err (reject).
// Optional macro SPI_READBACK_EN adds the read-frame tx path on cipo.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cs_n,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FW    = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FW + 2);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FW-1:0]      shreg;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic               frame_rw;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               addr_ok;
  logic [FW-1:0]      next_sh;

  assign frame_rw   = shreg[FW-1];
  assign frame_addr = shreg[FW-2 -: ADDR_W];
  assign frame_data = shreg[DATA_W-1:0];
  assign addr_ok    = ({1'b0, frame_addr} < (ADDR_W+1)'(NUM_REGS));
  assign next_sh    = {shreg[FW-2:0], copi_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          shreg <= '0;
          if (cs_fall) state <= SHIFT;
        end
        SHIFT: begin
          // cs_n rising wins over an sclk edge seen in the same cycle.
          if (cs_rise) begin
            state <= CHECK;
          end else if (sclk_rise) begin
            shreg <= next_sh;
            if (cnt != CNT_W'(FW + 1)) cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          if (cnt == CNT_W'(FW) && frame_rw == RW_WRITE && addr_ok) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (frame_addr == ADDR_W'(k)) regs[k] <= frame_data;
            wr_strobe <= 1'b1;
            wr_addr   <= frame_addr;
          end else if (!(cnt == CNT_W'(FW) && frame_rw == RW_READ)) begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx;
  logic              tx_hold;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rx_addr;
  logic              rx_rw;

  // Address bits as they stand once the sclk edge being handled lands.
  assign rx_addr = next_sh[ADDR_W-1:0];
  assign rx_rw   = next_sh[ADDR_W];

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rx_addr == ADDR_W'(k)) rd_data = regs[k];
  end

  // The falling edge right after the load belongs to the last address bit;
  // the MSB must survive it so the master samples it on the next rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= '0;
      tx_hold <= 1'b0;
    end else if (state != SHIFT) begin
      tx      <= '0;
      tx_hold <= 1'b0;
    end else if (!cs_rise) begin
      if (sclk_rise && cnt == CNT_W'(ADDR_W) && rx_rw == RW_READ) begin
        tx      <= rd_data;
        tx_hold <= 1'b1;
      end else if (sclk_fall) begin
        if (tx_hold) tx_hold <= 1'b0;
        else         tx      <= {tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign cipo = tx[DATA_W-1] & ~cs_lvl;

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};
`else
  assign cipo = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{cs_lvl, sclk_lvl, sclk_fall, copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Scoreboard bench for spi_regfile: expected commit/reject events are queued
// as frames are driven and matched against wr_strobe / frame_err pulses.
module tb_spi_regfile;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int HALF     = 4;
  localparam int BANK_W   = NUM_REGS * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs_n = 1'b1;
  logic              sclk = 1'b0;
  logic              copi = 1'b0;
  logic              cipo;
  logic [BANK_W-1:0] regs_o;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_err;

  spi_regfile #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .copi(copi),
    .cipo(cipo), .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] regs;
  } exp_t;

  exp_t              exp_q[$];
  logic [BANK_W-1:0] model = '0;
  int                compared = 0;
  int                mismatched = 0;

  // Scoreboard side: every strobe or error pulse must match the oldest
  // expectation.
  always @(negedge clk) begin
    if (rst_n && (wr_strobe || frame_err)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got wr_strobe=%0b frame_err=%0b, required none",
                 wr_strobe, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({wr_strobe, frame_err} !== {e.is_wr, ~e.is_wr}) begin
          mismatched++;
          $display("FAIL event_kind: got strobe/err=%b%b, required %b%b",
                   wr_strobe, frame_err, e.is_wr, ~e.is_wr);
        end else if (e.is_wr && (wr_addr !== e.addr || regs_o !== e.regs)) begin
          mismatched++;
          $display("FAIL commit: got addr=%0d regs=%h, required addr=%0d regs=%h",
                   wr_addr, regs_o, e.addr, e.regs);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] mk_frame(input logic rw, input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d);
    return {rw, a, d};
  endfunction

  // Clocks n bits out MSB first; rx collects cipo just before each rising sclk.
  task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(HALF);
      rx = {rx[30:0], cipo};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    copi = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, output logic [31:0] rx);
    cs_n = 1'b0;
    wait_clk(HALF);
    shift_bits(bits, n, rx);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    model[a*DATA_W +: DATA_W] = d;
    e.is_wr = 1'b1; e.addr = a; e.regs = model;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_wr = 1'b0; e.addr = '0; e.regs = model;
    exp_q.push_back(e);
  endtask

  // Every queued expectation must have been consumed, and the bank must
  // match the model.
  task automatic settle(input string name);
    wait_clk(12);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_pending: %0d expected events never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
    compared++;
    if (regs_o !== model) begin
      mismatched++;
      $display("FAIL %s_regs: got %h, required %h", name, regs_o, model);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    compared++;
    if ({regs_o, wr_strobe, wr_addr, frame_err, cipo} !== '0) begin
      mismatched++;
      $display("FAIL %s: got regs=%h strobe=%b addr=%0d err=%b cipo=%b, required all 0",
               name, regs_o, wr_strobe, wr_addr, frame_err, cipo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    wait_clk(5);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_write_single();
    logic [31:0] rx;
    expect_write(7'd2, 8'hA5);
    send_bits({16'h0, mk_frame(1'b1, 7'd2, 8'hA5)}, 16, rx);
    settle("write_single");
    compared++;
    if (wr_addr !== 7'd2) begin
      mismatched++;
      $display("FAIL write_single_addr_hold: got %0d, required 2", wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    expect_write(7'd0, 8'h11);
    send_bits({16'h0, mk_frame(1'b1, 7'd0, 8'h11)}, 16, rx);
    expect_write(7'd1, 8'h22);
    send_bits({16'h0, mk_frame(1'b1, 7'd1, 8'h22)}, 16, rx);
    settle("back_to_back");
  endtask

  task automatic test_bad_length();
    logic [31:0] rx;
    logic [15:0] f;
    f = mk_frame(1'b1, 7'd3, 8'h5C);
    expect_err();
    send_bits({17'h0, f[15:1]}, 15, rx);
    settle("short_frame");
    expect_err();
    send_bits({15'h0, f, 1'b1}, 17, rx);
    settle("long_frame");
  endtask

  task automatic test_bad_addr();
    logic [31:0] rx;
    expect_err();
    send_bits({16'h0, mk_frame(1'b1, 7'd7, 8'hEE)}, 16, rx);
    settle("bad_addr");
  endtask

  task automatic test_read();
    logic [31:0] rx;
`ifdef SPI_READBACK_EN
    expect_write(7'd4, 8'h3C);
    send_bits({16'h0, mk_frame(1'b1, 7'd4, 8'h3C)}, 16, rx);
    settle("read_setup");
    send_bits({16'h0, mk_frame(1'b0, 7'd4, 8'h00)}, 16, rx);
    settle("read_frame");
    compared++;
    if (rx[7:0] !== 8'h3C) begin
      mismatched++;
      $display("FAIL readback_data: got %h, required 3c", rx[7:0]);
    end
`else
    send_bits({16'h0, mk_frame(1'b0, 7'd2, 8'h00)}, 16, rx);
    settle("read_ignored");
    compared++;
    if (rx !== '0) begin
      mismatched++;
      $display("FAIL cipo_idle: got %h, required 0", rx);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx;
    logic [15:0] f;
    f = mk_frame(1'b1, 7'd1, 8'h77);
    cs_n = 1'b0;
    wait_clk(HALF);
    shift_bits({24'h0, f[15:8]}, 8, rx);
    rst_n = 1'b0;
    model = '0;
    exp_q.delete();
    wait_clk(3);
    check_outputs_zero("reset_mid_frame");
    rst_n = 1'b1;
    shift_bits({24'h0, f[7:0]}, 8, rx);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(10);
    settle("reset_tail_ignored");
    expect_write(7'd1, 8'h5A);
    send_bits({16'h0, mk_frame(1'b1, 7'd1, 8'h5A)}, 16, rx);
    settle("after_reset_frame");
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_back_to_back();
    test_bad_length();
    test_bad_addr();
    test_read();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
Name: spi_regfile

Overview:
- SPI mode-0 write/read peripheral feeding a parametrised bank of control registers.
- Successor to the fixed five-register SPI slave: adds width/depth parameters, persistent register storage, frame validation and a write strobe.
- All SPI pins are synchronised into the clk domain and processed by one FSM; no logic is clocked by sclk.
- Sits between the chip pins and downstream consumers (PWM, config).

Parameters:
- NUM_REGS, 5, number of registers; legal 1..2**ADDR_W.
- DATA_W, 8, bits per register.
- ADDR_W, 7, address field width.
- SYNC_STAGES, 2, flip-flop stages on each SPI input; minimum 2.

Ports:
- clk  in  1  system clock; f_clk >= 6 x f_sclk.
- rst_n  in  1  reset: asynchronous, active-low.
- cs_n  in  1  chip select, active-low, asynchronous.
- sclk  in  1  SPI clock, asynchronous.
- copi  in  1  serial data in, MSB first.
- cipo  out  1  serial data out; used only with SPI_READBACK_EN.
- regs_o  out  NUM_REGS*DATA_W  flattened register bank; reg k occupies bits [k*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse on each committed write.
- wr_addr  out  ADDR_W  address of the last committed write.
- frame_err  out  1  one-clk pulse when a frame is rejected.

Behaviour:
- Frame format: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first. Bit[MSB] is rw (1 = write). Then the address, then the data.
- Sampling: cs_n, sclk and copi each pass through SYNC_STAGES flops. A rising edge of synced sclk is detected by comparing against a one-flop delayed copy.
- FSM states:
  - IDLE: clears the bit counter and shift register. Moves to SHIFT on a synced cs_n falling edge.
  - SHIFT: each synced sclk rising edge shifts synced copi into the LSB of the shift register; the bit counter saturates at FRAME_W+1. A synced cs_n rising edge moves to CHECK.
  - CHECK: one cycle, then always returns to IDLE.
    - If count==FRAME_W, rw=1 and addr<NUM_REGS: write the data into reg[addr], pulse wr_strobe and load wr_addr.
    - If count==FRAME_W and rw=0: no action.
    - Otherwise: pulse frame_err, no register change.
- Latency: the register update and wr_strobe appear SYNC_STAGES+2 clk cycles after the cs_n pin rises.
- Registers hold their values between frames. They are never cleared except by reset. Registers that are not addressed are never touched.
- Simultaneous events: an sclk edge detected in the same clk cycle as the cs_n rise is ignored.
- Boundary conditions:
  - Fewer or more than FRAME_W sclk edges: frame_err.
  - Out-of-range address: frame_err.
  - cs_n falling again while in CHECK: the frame start is missed and the next frame is ignored until cs_n next goes high then low.
- Reset values: regs_o=0, wr_strobe=0, wr_addr=0, frame_err=0, cipo=0, FSM=IDLE, synchroniser flops=1 for cs_n and 0 for the others.
- Reset mid-frame: asynchronous clear; the partial frame is lost. If cs_n is already low when reset releases, that frame is ignored, because SHIFT is entered only on a falling edge.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - In a read frame (rw=0), once 1+ADDR_W bits have been received, reg[addr] (or 0 if out of range) is loaded into a tx shift register.
  - cipo presents the tx MSB; the next bit is shifted out on each synced sclk falling edge.
  - cipo returns to 0 when cs_n is high.
  - Read frames of the wrong length still pulse frame_err.
- Undefined: cipo is tied to 0, the tx logic is absent, and read frames are silently ignored.

Decomposition:
- Package spi_regfile_pkg holds the FSM state encodings (IDLE, SHIFT, CHECK), the RW_WRITE/RW_READ constants and the FRAME_W derivation function.
- One sub-module, spi_sync_edge: an N-stage synchroniser with rise/fall pulse outputs, instantiated three times.

Test Plan:
- Write frame 1_0000010_10100101 -> reg2=0xA5, other registers 0, one wr_strobe with wr_addr=2, no frame_err.
- Write reg0=0x11, then reg1=0x22 -> both values held afterwards; reg0 is still 0x11.
- 15-bit frame, then 17-bit frame, both addressed to reg3 -> two frame_err pulses, reg3 unchanged at 0.
- Write to address 7 with NUM_REGS=5 -> frame_err, regs_o unchanged, no wr_strobe.
- rst_n asserted after 8 bits of a write to reg1 -> all outputs 0; completing that frame's bits causes no update; the next clean frame works.
- With SPI_READBACK_EN: after reg4=0x3C, a read frame 0_0000100_xxxxxxxx -> cipo shifts 0,0,1,1,1,1,0,0 on the last 8 sclk cycles.
